// File: rtl/parking_slot_allocator.sv
// parking_slot_allocator
// This block tracks an 8-slot parking lot as an occupancy bitmap.
// - Entry requests are granted the lowest free slot.
// - Exit requests release the addressed slot.
// - Every accepted event holds the gate open for GATE_CYCLES cycles.
// - When both requests arrive together, the exit is served first.
// Optional feature: define PARK_STATS_EN to add the saturating
// total_entries counter and its output port.
module parking_slot_allocator #(
    parameter int unsigned GATE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [2:0] exit_slot,
    output logic       entry_ack,
    output logic       entry_nack,
    output logic [2:0] slot_id,
    output logic       exit_ack,
    output logic       exit_err,
    output logic [7:0] new_capacity,
`ifdef PARK_STATS_EN
    output logic [7:0] total_entries,
`endif
    output logic       gate_open,
    output logic       full,
    output logic       empty
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECIDE = 2'd1,
        GATE   = 2'd2
    } state_t;

    localparam logic [3:0] GATE_LOAD_C = 4'(GATE_CYCLES);

    // Returns {found, index} of the lowest-numbered free slot.
    function automatic logic [3:0] lowest_free(input logic [7:0] map);
        logic [3:0] res;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (!map[i]) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

    state_t     state_r, next_state_s;
    logic [7:0] cap_r, cap_next_s;
    logic [2:0] slot_id_r, slot_id_next_s;
    logic [3:0] gate_cnt_r, gate_cnt_next_s;
    logic       is_exit_r, is_exit_next_s;
    logic [2:0] slot_lat_r, slot_lat_next_s;
    logic       entry_ack_r, entry_nack_r, exit_ack_r, exit_err_r, gate_open_r;
    logic       entry_ack_s, entry_nack_s, exit_ack_s, exit_err_s;
    logic [3:0] free_s;

    assign free_s = lowest_free(cap_r);

    // Next-state and datapath decisions for the IDLE/DECIDE/GATE controller.
    always_comb begin
        next_state_s    = state_r;
        cap_next_s      = cap_r;
        slot_id_next_s  = slot_id_r;
        gate_cnt_next_s = gate_cnt_r;
        is_exit_next_s  = is_exit_r;
        slot_lat_next_s = slot_lat_r;
        entry_ack_s     = 1'b0;
        entry_nack_s    = 1'b0;
        exit_ack_s      = 1'b0;
        exit_err_s      = 1'b0;
        case (state_r)
            IDLE: begin
                // Exit wins a tie; the held entry request is picked up on a later pass.
                if (exit_req) begin
                    next_state_s    = DECIDE;
                    is_exit_next_s  = 1'b1;
                    slot_lat_next_s = exit_slot;
                end else if (entry_req) begin
                    next_state_s    = DECIDE;
                    is_exit_next_s  = 1'b0;
                end else begin
                    next_state_s    = IDLE;
                end
            end
            DECIDE: begin
                if (is_exit_r) begin
                    if (cap_r[slot_lat_r]) begin
                        cap_next_s[slot_lat_r] = 1'b0;
                        exit_ack_s             = 1'b1;
                        gate_cnt_next_s        = GATE_LOAD_C;
                        next_state_s           = GATE;
                    end else begin
                        exit_err_s             = 1'b1;
                        next_state_s           = IDLE;
                    end
                end else begin
                    if (free_s[3]) begin
                        cap_next_s[free_s[2:0]] = 1'b1;
                        slot_id_next_s          = free_s[2:0];
                        entry_ack_s             = 1'b1;
                        gate_cnt_next_s         = GATE_LOAD_C;
                        next_state_s            = GATE;
                    end else begin
                        entry_nack_s            = 1'b1;
                        next_state_s            = IDLE;
                    end
                end
            end
            GATE: begin
                if (gate_cnt_r <= 4'd1) begin
                    gate_cnt_next_s = 4'd0;
                    next_state_s    = IDLE;
                end else begin
                    gate_cnt_next_s = gate_cnt_r - 4'd1;
                    next_state_s    = GATE;
                end
            end
            default: begin
                next_state_s    = IDLE;
                gate_cnt_next_s = 4'd0;
            end
        endcase
    end

    // State, bitmap, latched request and registered output pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cap_r        <= 8'h00;
            slot_id_r    <= 3'd0;
            gate_cnt_r   <= 4'd0;
            is_exit_r    <= 1'b0;
            slot_lat_r   <= 3'd0;
            entry_ack_r  <= 1'b0;
            entry_nack_r <= 1'b0;
            exit_ack_r   <= 1'b0;
            exit_err_r   <= 1'b0;
            gate_open_r  <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            cap_r        <= cap_next_s;
            slot_id_r    <= slot_id_next_s;
            gate_cnt_r   <= gate_cnt_next_s;
            is_exit_r    <= is_exit_next_s;
            slot_lat_r   <= slot_lat_next_s;
            entry_ack_r  <= entry_ack_s;
            entry_nack_r <= entry_nack_s;
            exit_ack_r   <= exit_ack_s;
            exit_err_r   <= exit_err_s;
            gate_open_r  <= (next_state_s == GATE);
        end
    end

`ifdef PARK_STATS_EN
    logic [7:0] total_entries_r;

    // Saturating count of granted entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_entries_r <= 8'd0;
        end else if (entry_ack_s && (total_entries_r != 8'hFF)) begin
            total_entries_r <= total_entries_r + 8'd1;
        end else begin
            total_entries_r <= total_entries_r;
        end
    end

    assign total_entries = total_entries_r;
`endif

    assign entry_ack    = entry_ack_r;
    assign entry_nack   = entry_nack_r;
    assign exit_ack     = exit_ack_r;
    assign exit_err     = exit_err_r;
    assign slot_id      = slot_id_r;
    assign new_capacity = cap_r;
    assign gate_open    = gate_open_r;
    assign full         = (cap_r == 8'hFF);
    assign empty        = (cap_r == 8'h00);

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Scoreboard bench for parking_slot_allocator.
// A lot model (an array of occupied flags) predicts each response and queues it.
// A negedge monitor pops a queued response whenever a pulse appears and compares it.
module tb_parking_slot_allocator;

    localparam int GATE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       entry_req, exit_req;
    logic [2:0] exit_slot;
    logic       entry_ack, entry_nack, exit_ack, exit_err;
    logic [2:0] slot_id;
    logic [7:0] new_capacity;
    logic       gate_open, full, empty;
`ifdef PARK_STATS_EN
    logic [7:0] total_entries;
`endif

    parking_slot_allocator #(.GATE_CYCLES(GATE)) dut (
        .clk(clk), .reset(reset),
        .entry_req(entry_req), .exit_req(exit_req), .exit_slot(exit_slot),
        .entry_ack(entry_ack), .entry_nack(entry_nack), .slot_id(slot_id),
        .exit_ack(exit_ack), .exit_err(exit_err), .new_capacity(new_capacity),
`ifdef PARK_STATS_EN
        .total_entries(total_entries),
`endif
        .gate_open(gate_open), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Response kinds: 0 entry_ack, 1 entry_nack, 2 exit_ack, 3 exit_err
    typedef struct {
        int         kind;
        int         slot;
        logic [7:0] map;
    } exp_t;

    exp_t exp_q[$];
    bit   occ[8];
    int   last_slot = 0;
    int   entries_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] model_map();
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 8; i++) if (occ[i]) m = m | (8'h01 << i);
        return m;
    endfunction

    task automatic predict_entry();
        exp_t e;
        int   pick;
        pick = -1;
        for (int i = 0; i < 8; i++) if (!occ[i] && pick < 0) pick = i;
        if (pick >= 0) begin
            occ[pick] = 1'b1;
            last_slot = pick;
            if (entries_m < 255) entries_m++;
            e.kind = 0;
        end else begin
            e.kind = 1;
        end
        e.slot = last_slot;
        e.map  = model_map();
        exp_q.push_back(e);
    endtask

    task automatic predict_exit(input int s);
        exp_t e;
        if (occ[s]) begin
            occ[s] = 1'b0;
            e.kind = 2;
        end else begin
            e.kind = 3;
        end
        e.slot = last_slot;
        e.map  = model_map();
        exp_q.push_back(e);
    endtask

    // Issue one request (entry, exit or both), wait for all responses and for the gate to close.
    task automatic run_txn(input logic e, input logic x, input logic [2:0] s);
        int cyc;
        bit first;
        if (x) predict_exit(int'(s));
        if (e) predict_entry();
        @(posedge clk);
        #1;
        entry_req = e;
        exit_req  = x;
        exit_slot = s;
        cyc   = 0;
        first = 1'b1;
        while ((entry_req || exit_req) && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (exit_ack || exit_err) begin
                exit_req = 1'b0;
                if (first) chk("latency_exit", cyc, 2);
                first = 1'b0;
            end
            if (entry_ack || entry_nack) begin
                entry_req = 1'b0;
                if (first) chk("latency_entry", cyc, 2);
                first = 1'b0;
            end
        end
        if (entry_req || exit_req) begin
            checks++;
            errors++;
            $display("FAIL response_timeout actual=none required=pulse");
            entry_req = 1'b0;
            exit_req  = 1'b0;
        end
        cyc = 0;
        while (gate_open && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (gate_open) begin
            checks++;
            errors++;
            $display("FAIL gate_close_timeout actual=1 required=0");
        end
    endtask

    task automatic reset_checks();
        chk("rst_map", new_capacity, 8'h00);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_slot", slot_id, 3'd0);
        chk("rst_gate", gate_open, 1'b0);
        chk("rst_pulses", {entry_ack, entry_nack, exit_ack, exit_err}, 4'b0000);
`ifdef PARK_STATS_EN
        chk("rst_total", total_entries, 8'd0);
`endif
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) occ[i] = 1'b0;
        last_slot = 0;
        entries_m = 0;
    endtask

    // Monitor: compare every response pulse and every gate window against the model.
    int run = 0;
    always @(negedge clk) begin
        exp_t e;
        int   k;
        if (reset) begin
            run = 0;
        end else begin
            if (gate_open) begin
                run++;
            end else if (run > 0) begin
                chk("gate_len", run, GATE);
                run = 0;
            end
            if (entry_ack || entry_nack || exit_ack || exit_err) begin
                chk("one_pulse", 32'(entry_ack) + 32'(entry_nack) + 32'(exit_ack) + 32'(exit_err), 1);
                k = entry_ack ? 0 : entry_nack ? 1 : exit_ack ? 2 : 3;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse actual=kind%0d required=none", k);
                end else begin
                    e = exp_q.pop_front();
                    chk("kind", k, e.kind);
                    chk("slot_id", slot_id, e.slot);
                    chk("bitmap", new_capacity, e.map);
                    chk("full", full, e.map == 8'hFF);
                    chk("empty", empty, e.map == 8'h00);
                    chk("gate_at_pulse", gate_open, (e.kind == 0) || (e.kind == 2));
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        exit_slot = 3'd0;
        clear_model();
        #12;
        reset_checks();
        @(negedge clk);
        reset = 1'b0;

        // First entry after reset: slot 0, bitmap 01, gate held for GATE cycles.
        run_txn(1'b1, 1'b0, 3'd0);
        // Fill the lot, free slot 2 (bitmap FB), refill it, then overflow.
        for (int i = 0; i < 7; i++) run_txn(1'b1, 1'b0, 3'd0);
        run_txn(1'b0, 1'b1, 3'd2);
        run_txn(1'b1, 1'b0, 3'd0);
        run_txn(1'b1, 1'b0, 3'd0);
        // Build bitmap 05, release slot 2, then release the empty slot 1.
        run_txn(1'b0, 1'b1, 3'd1);
        for (int i = 3; i < 8; i++) run_txn(1'b0, 1'b1, 3'(i));
        run_txn(1'b0, 1'b1, 3'd2);
        run_txn(1'b0, 1'b1, 3'd1);
        // Simultaneous exit of slot 0 and entry: exit served first.
        run_txn(1'b1, 1'b1, 3'd0);

        // Random mix of entries, exits and collisions.
        for (int n = 0; n < 60; n++) begin
            logic e, x;
            e = 1'($urandom_range(0, 1));
            x = 1'($urandom_range(0, 1));
            if (!e && !x) e = 1'b1;
            run_txn(e, x, 3'($urandom_range(0, 7)));
        end

        // Reset while an entry sits in DECIDE, with a non-empty lot.
        run_txn(1'b1, 1'b0, 3'd0);
        @(posedge clk);
        #1;
        entry_req = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        entry_req = 1'b0;
        reset_checks();
        clear_model();
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_rst_map", new_capacity, 8'h00);
        chk("post_rst_gate", gate_open, 1'b0);

`ifdef PARK_STATS_EN
        for (int n = 0; n < 300; n++) begin
            run_txn(1'b1, 1'b0, 3'd0);
            run_txn(1'b0, 1'b1, 3'd0);
        end
        chk("total_entries", total_entries, 8'(entries_m));
        chk("total_sat", total_entries, 8'd255);
`endif

        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_slot_allocator.md
PARKING_SLOT_ALLOCATOR -- requirements
Module: parking_slot_allocator

Interface
REQ-001 SHALL have parameter: GATE_CYCLES, default 4, number of cycles gate_open is held high after each accepted event (legal range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: entry_req  input  1  car at entry gate requests a slot; level, held until entry_ack or entry_nack.
REQ-005 SHALL have port: exit_req  input  1  car at exit gate releases a slot; level, held until exit_ack or exit_err.
REQ-006 SHALL have port: exit_slot  input  3  index of the slot being released, valid while exit_req is high.
REQ-007 SHALL have port: entry_ack  output  1  one-cycle pulse, slot granted.
REQ-008 SHALL have port: entry_nack  output  1  one-cycle pulse, lot full, request refused.
REQ-009 SHALL have port: slot_id  output  3  granted slot index, valid in the entry_ack cycle and held until the next grant.
REQ-010 SHALL have port: exit_ack  output  1  one-cycle pulse, slot released.
REQ-011 SHALL have port: exit_err  output  1  one-cycle pulse, exit_slot was not occupied.
REQ-012 SHALL have port: new_capacity  output  8  occupancy bitmap, bit i = 1 means slot i occupied; feeds the parked-count popcount logic.
REQ-013 SHALL have port: gate_open  output  1  high for GATE_CYCLES cycles after each ack.
REQ-014 SHALL have port: full / empty  output  1 each  new_capacity == 8'hFF / 8'h00, combinational from the register.

Function
REQ-015 SHALL implement FSM states IDLE, DECIDE, GATE.
REQ-016 SHALL sample requests only in IDLE; any request seen in IDLE moves to DECIDE on the next edge, latching the request type and exit_slot.
REQ-017 SHALL give exit priority when entry_req and exit_req are both high in the same IDLE cycle; entry is served on a later pass.
REQ-018 SHALL, for an entry in DECIDE with not full: set the lowest-index zero bit of new_capacity, drive slot_id to that index, pulse entry_ack, go to GATE.
REQ-019 SHALL, for an entry in DECIDE with full: leave the bitmap unchanged, pulse entry_nack, return to IDLE.
REQ-020 SHALL, for an exit in DECIDE with the addressed bit = 1: clear that bit, pulse exit_ack, go to GATE.
REQ-021 SHALL, for an exit in DECIDE with the addressed bit = 0: leave the bitmap unchanged, pulse exit_err, return to IDLE.
REQ-022 SHALL hold gate_open high for exactly GATE_CYCLES cycles in GATE using a 4-bit down-counter, then return to IDLE.
REQ-023 SHALL ignore entry_req and exit_req while in DECIDE or GATE.
REQ-024 SHALL make the ack/nack/err pulse visible two cycles after the request is first high in IDLE, with the bitmap update visible in the same cycle.
REQ-025 SHALL never assert more than one of entry_ack, entry_nack, exit_ack, exit_err in the same cycle.

Reset
REQ-026 SHALL, on reset high, asynchronously force: state=IDLE, new_capacity=8'h00, slot_id=0, gate counter=0, all pulses and gate_open=0, empty=1, full=0.
REQ-027 SHALL abandon any in-progress transaction if reset occurs mid-operation, with no ack pulse after reset deasserts.

Configuration
REQ-028 SHALL, when PARK_STATS_EN is defined, add output total_entries[7:0]: counts entry_ack pulses, saturates at 255, reset to 0.
REQ-029 SHALL, when PARK_STATS_EN is not defined, omit the total_entries port and counter entirely, with all other behaviour identical.

Verification
REQ-030 SHALL cover: reset, then entry_req held -> entry_ack at cycle 2, slot_id=0, new_capacity=8'h01, gate_open high 4 cycles.
REQ-031 SHALL cover: bitmap 8'hFB, entry_req -> slot_id=2, new_capacity=8'hFF, full=1; a further entry_req -> entry_nack, bitmap unchanged.
REQ-032 SHALL cover: bitmap 8'h05, exit_req with exit_slot=2 -> exit_ack, new_capacity=8'h01; exit_slot=1 -> exit_err, bitmap stays 8'h01.
REQ-033 SHALL cover: bitmap 8'h01, entry_req and exit_req(slot 0) high together -> exit_ack first (bitmap 8'h00), then after GATE, entry_ack slot 0.
REQ-034 SHALL cover: reset pulsed in DECIDE during an entry -> bitmap 8'h00, no entry_ack, gate_open=0.
REQ-035 SHALL cover, with PARK_STATS_EN defined: 300 entry/exit pairs -> total_entries=255.
